imm_rot_encoder: RTL and testbench
==================================

Name: imm_rot_encoder

Overview:
- Inverse of the datapath's Val2 immediate expansion: takes a 32-bit constant and searches for an 8-bit immediate plus 4-bit rotate that reproduce it as ROR(imm_8, 2*rotate_imm).
- Emits the 12-bit shift_operand field {rotate_imm, imm_8} for the instruction encoder / test-program generator feeding instruction memory.
- Multi-cycle iterative search, one rotation checked per cycle, with valid/ready handshakes on both sides.

Parameters:
- ROT_STEPS, 16, number of rotate values searched (fixed by the 4-bit rotate field; must be 16).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  value presented for encoding.
- in_ready  output  1  block idle and able to accept a value.
- in_value  input  32  constant to encode.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- found  output  1  1 = in_value is encodable.
- shift_operand  output  12  {rotate_imm[3:0], imm_8[7:0]}; 0 when found=0.
- inverted  output  1  result encodes ~in_value (MVN form); tied 0 unless NEG_SEARCH_EN.

Behaviour:
- Reset (clk edge with rst=1): state IDLE; out_valid=0, found=0, shift_operand=0, inverted=0, in_ready=0 while rst high; rotation counter=0. Reset in any state, including mid-SEARCH or DONE, aborts and discards the operation.
- in_ready = (state==IDLE) & ~rst.
- States: IDLE, SEARCH, DONE.
- IDLE: on in_valid & in_ready, latch in_value into an internal register, clear the counter, go to SEARCH. Call this cycle T.
- SEARCH: check k = 0,1,2,... one per cycle starting at T+1. At check k with rot = k mod 16, the candidate is ROL(value, 2*rot), 32-bit circular. Match when candidate[31:8]==0. On match: found=1, shift_operand={rot, candidate[7:0]}, go to DONE. out_valid rises at T+k+2.
- First match wins, so the smallest rotate is canonical. Value 0 yields rot 0, imm 0, found=1.
- No match after the last check (k=15; k=31 with the feature enabled): found=0, shift_operand=0, inverted=0, go to DONE. out_valid rises at T+17 (T+33 with the feature).
- in_value and in_valid are ignored while in SEARCH or DONE (in_ready=0). The latched value is used, so in_value may change after acceptance.
- DONE: out_valid=1; found, shift_operand and inverted stay stable until out_valid & out_ready. On that cycle go to IDLE, with out_valid=0 the next cycle and in_ready=1 the next cycle.
- No back-to-back overlap: a new accept can occur at the earliest one cycle after the result handshake.
- Check: ROR({24'b0, shift_operand[7:0]}, 2*shift_operand[11:8]) == in_value (or ~in_value when inverted=1) whenever found=1.

Optional Feature:
- Macro NEG_SEARCH_EN.
- Defined:
  - After the positive pass (k=0..15) fails, run an inverted pass k=16..31 on ~value, same rotation order.
  - A match there sets inverted=1, found=1.
  - The positive pass always takes priority.
  - Worst-case latency is T+33.
- Undefined:
  - Single pass only; worst-case latency T+17.
  - inverted is a constant 0; no extra logic is generated.

Test Plan:
- in_value=0x000000AB accepted at T -> out_valid at T+2, found=1, shift_operand=0x0AB, inverted=0.
- in_value=0xFF000000 -> out_valid at T+6, found=1, shift_operand=0x4FF. in_value=0xC000003F -> out_valid at T+3, shift_operand=0x1FF.
- in_value=0x00000102 (not encodable) -> out_valid at T+17, found=0, shift_operand=0x000 (no macro).
- Handshake: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid pulse is ignored. Raise out_ready -> in_ready=1 next cycle, next value is accepted correctly.
- Assert rst at T+4 during a 0xFF000000 search -> next cycle state is IDLE, out_valid=0, shift_operand=0, in_ready=1 after rst drops. A following 0x000000AB encodes correctly.
- NEG_SEARCH_EN defined, in_value=0xFFFFFF00 -> out_valid at T+18, found=1, inverted=1, shift_operand=0x0FF. Without the macro -> T+17, found=0.

Source files
------------

// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: iterative search for {rotate_imm, imm_8} with ROR(imm_8, 2*rotate_imm) == in_value, one rotate per cycle.
// Optional NEG_SEARCH_EN macro adds a second pass on ~in_value (MVN form) once the positive pass fails.
module imm_rot_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        found,
    output logic [11:0] shift_operand,
    output logic        inverted
);

`ifdef NEG_SEARCH_EN
    localparam int CNT_W = 5;
    localparam int LAST  = 2 * ROT_STEPS - 1;
`else
    localparam int CNT_W = 4;
    localparam int LAST  = ROT_STEPS - 1;
`endif

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        value_q, value_d;
    logic               found_q, found_d;
    logic [11:0]        shop_q, shop_d;
    logic [3:0]         rot;
    logic [4:0]         lsh;
    logic [5:0]         rsh;
    logic [31:0]        src;
    logic [31:0]        cand;
    logic               match;

    // Rotating left by 2*rot undoes the immediate's ROR; a fit leaves only the low byte set.
    assign rot   = cnt_q[3:0];
    assign lsh   = {rot, 1'b0};
    assign rsh   = 6'd32 - {1'b0, lsh};
    assign cand  = (src << lsh) | (src >> rsh);
    assign match = (cand[31:8] == 24'd0);

`ifdef NEG_SEARCH_EN
    logic inv_q, inv_d;
    assign src      = cnt_q[4] ? ~value_q : value_q;
    assign inverted = inv_q;
`else
    assign src      = value_q;
    assign inverted = 1'b0;
`endif

    assign in_ready      = (state_q == IDLE) & ~rst;
    assign out_valid     = (state_q == DONE);
    assign found         = found_q;
    assign shift_operand = shop_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        found_d = found_q;
        shop_d  = shop_q;
`ifdef NEG_SEARCH_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    value_d = in_value;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    shop_d  = '0;
`ifdef NEG_SEARCH_EN
                    inv_d   = 1'b0;
`endif
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (match) begin
                    found_d = 1'b1;
                    shop_d  = {rot, cand[7:0]};
`ifdef NEG_SEARCH_EN
                    inv_d   = cnt_q[4];
`endif
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(LAST)) begin
                    found_d = 1'b0;
                    shop_d  = '0;
`ifdef NEG_SEARCH_EN
                    inv_d   = 1'b0;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            value_q <= '0;
            found_q <= 1'b0;
            shop_q  <= '0;
`ifdef NEG_SEARCH_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            found_q <= found_d;
            shop_q  <= shop_d;
`ifdef NEG_SEARCH_EN
            inv_q   <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Bench for imm_rot_encoder: directed vector table, handshake/reset sequences, and random values against a brute-force model.
module tb_imm_rot_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic        found;
    logic [11:0] shift_operand;
    logic        inverted;

    imm_rot_encoder #(.ROT_STEPS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_value      (in_value),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .found         (found),
        .shift_operand (shift_operand),
        .inverted      (inverted)
    );

    always #5 clk = ~clk;

`ifdef NEG_SEARCH_EN
    localparam int NPASS    = 2;
    localparam int MISS_LAT = 33;
`else
    localparam int NPASS    = 1;
    localparam int MISS_LAT = 17;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] v;
        int          lat;
        bit          fnd;
        logic [11:0] sop;
        bit          inv;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        logic [63:0] d;
        d = {x, x} >> s;
        return d[31:0];
    endfunction

    // Exhaustive search over every (rotate, imm_8) pair; first rotate that reproduces the value wins.
    task automatic ref_enc(input logic [31:0] v, output int lat, output bit fnd,
                           output logic [11:0] sop, output bit inv);
        logic [31:0] t;
        fnd = 1'b0;
        sop = '0;
        inv = 1'b0;
        lat = MISS_LAT;
        for (int p = 0; p < NPASS; p++) begin
            t = (p == 1) ? ~v : v;
            for (int r = 0; r < 16; r++) begin
                for (int i = 0; i < 256; i++) begin
                    if (!fnd && ror32(i, 2 * r) == t) begin
                        fnd = 1'b1;
                        sop = {r[3:0], i[7:0]};
                        inv = (p == 1);
                        lat = p * 16 + r + 2;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, output bit ok);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_value = v;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
        in_value = $urandom;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk($sformatf("%s_post_valid", tag), {31'd0, out_valid}, 32'd0);
        chk($sformatf("%s_post_ready", tag), {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [31:0] v, input int elat,
                           input bit efnd, input logic [11:0] esop, input bit einv);
        bit ok;
        int lat;
        send(v, ok);
        chk($sformatf("%s_accept", tag), {31'd0, ok}, 32'd1);
        wait_out(lat);
        chk($sformatf("%s_lat", tag), lat, elat);
        chk($sformatf("%s_found", tag), {31'd0, found}, {31'd0, efnd});
        chk($sformatf("%s_sop", tag), {20'd0, shift_operand}, {20'd0, esop});
        chk($sformatf("%s_inv", tag), {31'd0, inverted}, {31'd0, einv});
        release_out(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          lat;
        int          elat;
        bit          efnd;
        bit          einv;
        logic [11:0] esop;
        logic [31:0] v;
        int          late;

        tbl[0] = '{32'h000000AB, 2, 1'b1, 12'h0AB, 1'b0};
        tbl[1] = '{32'hFF000000, 6, 1'b1, 12'h4FF, 1'b0};
        tbl[2] = '{32'hC000003F, 3, 1'b1, 12'h1FF, 1'b0};
        tbl[3] = '{32'h00000102, MISS_LAT, 1'b0, 12'h000, 1'b0};
        tbl[4] = '{32'h00000000, 2, 1'b1, 12'h000, 1'b0};
        tbl[5] = '{32'h000003FC, 17, 1'b1, 12'hFFF, 1'b0};
        tbl[6] = '{32'h80000000, 3, 1'b1, 12'h102, 1'b0};
        tbl[7] = '{32'h000001FE, MISS_LAT, 1'b0, 12'h000, 1'b0};
`ifdef NEG_SEARCH_EN
        tbl[8] = '{32'hFFFFFF00, 18, 1'b1, 12'h0FF, 1'b1};
        tbl[9] = '{32'hFFFFFFFF, 18, 1'b1, 12'h000, 1'b1};
`else
        tbl[8] = '{32'hFFFFFF00, 17, 1'b0, 12'h000, 1'b0};
        tbl[9] = '{32'hFFFFFFFF, 17, 1'b0, 12'h000, 1'b0};
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_value  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_found", {31'd0, found}, 32'd0);
        chk("rst_sop", {20'd0, shift_operand}, 32'd0);
        chk("rst_inv", {31'd0, inverted}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i].v, tbl[i].lat, tbl[i].fnd, tbl[i].sop, tbl[i].inv);
        end

        // Consumer stalls: result must hold, and a new request must be ignored.
        send(32'hFF000000, ok);
        chk("hold_accept", {31'd0, ok}, 32'd1);
        wait_out(lat);
        chk("hold_lat", lat, 6);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_value = 32'h000000AB;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_found", {31'd0, found}, 32'd1);
            chk("hold_sop", {20'd0, shift_operand}, 32'h4FF);
            tick();
        end
        in_valid = 1'b0;
        release_out("hold");
        run_vec("after_hold", 32'hC000003F, 3, 1'b1, 12'h1FF, 1'b0);

        // Reset in the middle of a search discards it.
        send(32'hFF000000, ok);
        chk("abort_accept", {31'd0, ok}, 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_found", {31'd0, found}, 32'd0);
        chk("abort_sop", {20'd0, shift_operand}, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        late = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) late++;
            tick();
        end
        chk("abort_no_result", late, 0);
        run_vec("after_abort", 32'h000000AB, 2, 1'b1, 12'h0AB, 1'b0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1, 2:    v = ror32($urandom_range(0, 255), 2 * $urandom_range(0, 15));
                default: v = ~ror32($urandom_range(0, 255), 2 * $urandom_range(0, 15));
            endcase
            ref_enc(v, elat, efnd, esop, einv);
            run_vec($sformatf("rnd%0d_%08h", n, v), v, elat, efnd, esop, einv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
